// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU operation sequencer.
//   NUM_REGS_DEFAULT : default number of bus-attached registers
//   OP_*             : ALU OpControl encodings (OP_ILLEGAL is never issued)
//   state_t          : sequencer state encoding
package alu_pkg;

  localparam int NUM_REGS_DEFAULT = 4;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_AND     = 3'd3;
  localparam logic [2:0] OP_OR      = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD1  = 3'd1,
    ST_LD2  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/reg_sel_decode.sv
// reg_sel_decode -- register index to one-hot select.
//   idx : register index
//   en  : select enable; sel is all-zero when low
//   sel : one-hot select, NUM_REGS wide (all-zero for idx >= NUM_REGS)
module reg_sel_decode #(
  parameter int NUM_REGS = 4,
  parameter int RW       = 2
) (
  input  logic [RW-1:0]       idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (int'(idx) == i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer -- steps one ALU instruction over a shared register bus:
// load operand 1, load operand 2, execute (bus turnaround), write back.
//   clk, reset           : clock, asynchronous active-high reset
//   instr_valid/ready    : instruction handshake (ready only in IDLE)
//   instr_op/rs1/rs2/rd  : instruction fields, latched on handshake
//   reg_read_en          : one-hot register bus-drive select
//   reg_write_en         : one-hot register capture select
//   writeIN1/writeIN2    : ALU operand register load strobes
//   alu_out_en, alu_read : ALU result enable, ALU drives bus
//   alu_op               : ALU OpControl (0 while idle)
//   busy, done, err      : status; done/err are one-cycle pulses
// Build option: ALU_SEQ_UNARY_SKIP_EN -- when defined, NOT skips the LD2 step.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  localparam int RW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [2:0]          instr_op,
  input  logic [RW-1:0]       instr_rs1,
  input  logic [RW-1:0]       instr_rs2,
  input  logic [RW-1:0]       instr_rd,
  output logic [NUM_REGS-1:0] reg_read_en,
  output logic [NUM_REGS-1:0] reg_write_en,
  output logic                writeIN1,
  output logic                writeIN2,
  output logic                alu_out_en,
  output logic                alu_read,
  output logic [2:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t        state;
  logic [2:0]    op_q;
  logic [RW-1:0] rs1_q;
  logic [RW-1:0] rs2_q;
  logic [RW-1:0] rd_q;
  logic          err_q;
  logic          skip_ld2;
  logic          instr_legal;
  logic [RW-1:0] rd_idx;
  logic          rd_en;

  // Only reachable for non-power-of-two NUM_REGS.
  function automatic logic idx_ok(input logic [RW-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  assign instr_legal = (instr_op != OP_ILLEGAL) && idx_ok(instr_rs1) &&
                       idx_ok(instr_rs2) && idx_ok(instr_rd);

`ifdef ALU_SEQ_UNARY_SKIP_EN
  assign skip_ld2 = (op_q == OP_NOT);
`else
  assign skip_ld2 = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            rd_q  <= instr_rd;
            // Illegal instructions are dropped in place; err flags it next cycle.
            if (instr_legal) state <= ST_LD1;
            else             err_q <= 1'b1;
          end
        end
        ST_LD1:  state <= skip_ld2 ? ST_EXEC : ST_LD2;
        ST_LD2:  state <= ST_EXEC;
        ST_EXEC: state <= ST_WB;
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode; reset forces IDLE, so every strobe drops immediately.
  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign writeIN1    = (state == ST_LD1);
  assign writeIN2    = (state == ST_LD2);
  assign alu_out_en  = (state == ST_EXEC) || (state == ST_WB);
  assign alu_read    = (state == ST_WB);
  assign done        = (state == ST_WB);
  assign err         = err_q;
  assign alu_op      = busy ? op_q : 3'd0;

  // EXEC has no reader so the bus turns around between register and ALU drive.
  assign rd_en  = (state == ST_LD1) || (state == ST_LD2);
  assign rd_idx = (state == ST_LD1) ? rs1_q : rs2_q;

  reg_sel_decode #(.NUM_REGS(NUM_REGS), .RW(RW)) u_read_sel (
    .idx (rd_idx),
    .en  (rd_en),
    .sel (reg_read_en)
  );

  reg_sel_decode #(.NUM_REGS(NUM_REGS), .RW(RW)) u_write_sel (
    .idx (rd_q),
    .en  (state == ST_WB),
    .sel (reg_write_en)
  );

endmodule
